// File: rtl/pca9685_pkg.sv
// Shared PCA9685 register map constants, reader FSM states and the blob byte accessor.
package pca9685_pkg;

  localparam logic [7:0] MODE1         = 8'h00;
  localparam logic [7:0] LED0_ON_L     = 8'h06;
  localparam logic [7:0] LED15_OFF_H   = 8'h45;
  localparam logic [7:0] ALL_LED_ON_L  = 8'hFA;
  localparam logic [7:0] ALL_LED_OFF_H = 8'hFD;
  localparam logic [7:0] PRESCALE      = 8'hFE;

  localparam int MODE1_AI_BIT = 5;
  localparam int BLOB_BYTES   = 256;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_PRESENT,
    RD_WAIT_ACK
  } rd_state_e;

  // Blob is MSB-first per byte: byte i occupies bits [i*8 : i*8+7].
  function automatic logic [7:0] reg_byte(input logic [0:BLOB_BYTES*8-1] blob,
                                          input logic [7:0] addr);
    return blob[{addr, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/led_snapshot.sv
// Holds a coherent 4-byte copy of one LED channel so multi-byte reads are not torn.
module led_snapshot (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            capture_i,
  input  logic [7:0]      base_i,
  input  logic [3:0][7:0] bytes_i,
  input  logic [7:0]      addr_i,
  output logic            hit_o,
  output logic [7:0]      byte_o
);

  logic [3:0][7:0] snap_q;
  logic [7:0]      snap_base_q;
  logic            snap_valid_q;
  logic [7:0]      off;
  logic [7:0]      chan_base;

  assign off       = addr_i - 8'h06;
  assign chan_base = {off[7:2], 2'b00} + 8'h06;
  assign hit_o     = snap_valid_q && (snap_base_q == chan_base);
  assign byte_o    = snap_q[off[1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q       <= '0;
      snap_base_q  <= '0;
      snap_valid_q <= 1'b0;
    end else if (clear_i) begin
      snap_valid_q <= 1'b0;
    end else if (capture_i) begin
      snap_q       <= bytes_i;
      snap_base_q  <= base_i;
      snap_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/pca9685_register_reader.sv
// Serves I2C read bytes from the PCA9685 register image with auto-increment and LED snapshotting.
module pca9685_register_reader
  import pca9685_pkg::*;
#(
  parameter int NUM_REGS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [0:NUM_REGS*8-1] register_blob_i,
  input  logic                  set_pointer_i,
  input  logic [7:0]            pointer_i,
  input  logic                  read_req_i,
  input  logic                  byte_ack_i,
  input  logic                  stop_i,
  output logic [7:0]            read_data_o,
  output logic                  read_valid_o,
  output logic [7:0]            pointer_o,
  output logic                  busy_o
);

  rd_state_e       state_q, state_d;
  logic [7:0]      ptr_q, rdata_q, live_byte, fetch_byte, snap_byte, mode1;
  logic            in_led, in_blank, is_on_l, snap_hit, fetch_go, capture;
  logic [3:0][7:0] cap_bytes;

  assign live_byte = reg_byte(register_blob_i, ptr_q);
  assign mode1     = reg_byte(register_blob_i, MODE1);
  assign in_led    = (ptr_q >= LED0_ON_L) && (ptr_q <= LED15_OFF_H);
  // Reserved space and the write-only ALL_LED block both read back as zero.
  assign in_blank  = (ptr_q > LED15_OFF_H) && (ptr_q <= ALL_LED_OFF_H);
  assign is_on_l   = in_led && (ptr_q[1:0] == 2'b10);
  assign fetch_go  = (state_q == RD_FETCH) && !stop_i;
  assign capture   = fetch_go && is_on_l && !set_pointer_i;

  always_comb begin
    cap_bytes = '0;
    for (int k = 0; k < 4; k++)
      cap_bytes[k] = reg_byte(register_blob_i, ptr_q + 8'(k));
  end

  always_comb begin
    fetch_byte = live_byte;
    if (in_blank)
      fetch_byte = 8'h00;
    else if (in_led && !is_on_l && snap_hit)
      fetch_byte = snap_byte;
  end

  led_snapshot u_snap (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (set_pointer_i | stop_i),
    .capture_i (capture),
    .base_i    (ptr_q),
    .bytes_i   (cap_bytes),
    .addr_i    (ptr_q),
    .hit_o     (snap_hit),
    .byte_o    (snap_byte)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = RD_IDLE;
    end else begin
      case (state_q)
        RD_IDLE:     if (read_req_i) state_d = RD_FETCH;
        RD_FETCH:    state_d = RD_PRESENT;
        RD_PRESENT:  state_d = RD_WAIT_ACK;
        RD_WAIT_ACK: if (byte_ack_i)      state_d = RD_IDLE;
                     else if (read_req_i) state_d = RD_FETCH;
        default:     state_d = RD_IDLE;
      endcase
    end
  end

  // Pointer is retained across STOP, matching the real part.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                   ptr_q <= 8'h00;
    else if (set_pointer_i)                      ptr_q <= pointer_i;
    else if (stop_i)                             ptr_q <= ptr_q;
    else if (byte_ack_i && mode1[MODE1_AI_BIT])  ptr_q <= ptr_q + 8'h01;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         rdata_q <= 8'h00;
    else if (fetch_go) rdata_q <= fetch_byte;
  end

  assign read_data_o  = rdata_q;
  assign read_valid_o = (state_q == RD_PRESENT);
  assign busy_o       = (state_q == RD_FETCH) || (state_q == RD_PRESENT);
  assign pointer_o    = ptr_q;

endmodule

// File: doc/pca9685_register_reader.md
# pca9685_register_reader

Read-side counterpart of `register_data`: it serves I2C read transactions from the PCA9685 register image. It takes the flattened 256-byte `register_blob` and a pointer set by the I2C slave front end. On request it returns one byte per I2C read byte and applies the PCA9685 auto-increment rule. Multi-byte reads of a single LED channel return a coherent 4-byte snapshot, even while `register_data` updates that channel mid-burst.

## Interface
Parameters:
- `NUM_REGS`, 256: register image depth in bytes; the blob is `NUM_REGS*8` bits, MSB-first per byte (byte i = bits `[i*8 : i*8+7]`).

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `register_blob_i`  in  0:NUM_REGS*8-1  live register image from `register_data`.
- `set_pointer_i`  in  1  one-cycle strobe: load `pointer_i` as the new control-register pointer.
- `pointer_i`  in  8  pointer value from the I2C write phase.
- `read_req_i`  in  1  one-cycle strobe: the I2C engine needs the next read byte.
- `byte_ack_i`  in  1  one-cycle strobe: the master ACKed the byte just sent.
- `stop_i`  in  1  one-cycle strobe: I2C STOP or repeated START seen.
- `read_data_o`  out  8  byte to shift out; held until the next `read_req_i`.
- `read_valid_o`  out  1  one-cycle pulse: `read_data_o` is updated.
- `pointer_o`  out  8  current pointer, for debug and the bench.
- `busy_o`  out  1  high from `read_req_i` until `read_valid_o`.

## Operation
States:
- IDLE: wait for `read_req_i`.
- FETCH: select the source byte.
- PRESENT: drive the byte.
- WAIT_ACK: wait for the master's ACK/NACK.

Transitions:
- IDLE -> FETCH on `read_req_i`.
- FETCH -> PRESENT unconditionally.
- PRESENT -> WAIT_ACK unconditionally; `read_valid_o` pulses in PRESENT.
- WAIT_ACK -> IDLE on `byte_ack_i`.
- WAIT_ACK -> FETCH on `read_req_i`. A NACKed byte is not followed by a request.
- Any state -> IDLE on `stop_i`; the snapshot is invalidated.

Source selection at the pointer address A:
- A in 0x46–0xF9 (reserved): 0x00.
- A in 0xFA–0xFD (ALL_LED, write-only): 0x00.
- A in 0x06–0x45 with `(A-6)%4 == 0` (LEDn_ON_L): capture blob bytes A..A+3 into a 4-byte snapshot, set `snap_valid`, record `snap_base = A`, return the ON_L byte.
- A in 0x06–0x45 with offset k = 1..3 from its channel base: if `snap_valid` and `snap_base` is that base, return snapshot byte k; otherwise return the live byte.
- All other addresses: the live blob byte.

Pointer advance:
- On `byte_ack_i`, and only if MODE1[5] (AI, live blob byte 0x00 bit 5) is 1, the pointer increments by 1 mod 256 (0xFF -> 0x00).
- With AI = 0 the pointer holds and repeated reads return the same address.
- A NACK (no `byte_ack_i`) never advances the pointer.

Invalidation and priority:
- `set_pointer_i` loads the pointer and clears `snap_valid`.
- `stop_i` clears `snap_valid`; the pointer is retained, as on the PCA9685.
- Same-cycle priority: `set_pointer_i` > `stop_i` > `byte_ack_i` > `read_req_i`.
- `read_req_i` outside IDLE or WAIT_ACK is ignored.

## Timing
- Latency: `read_req_i` at cycle N -> `read_valid_o` and the new `read_data_o` at cycle N+2. The blob is sampled at N+1 (FETCH).
- `busy_o` is high during cycles N+1 and N+2.
- Pointer update is visible on `pointer_o` the cycle after `byte_ack_i`.
- Blob changes after the FETCH cycle do not alter the presented byte. Snapshot bytes ignore blob changes until invalidated.
- Reset values: state IDLE, `pointer_o` = 0x00, `read_data_o` = 0x00, `read_valid_o` = 0, `busy_o` = 0, `snap_valid` = 0.
- Reset asserted mid-transaction takes effect on the next edge; no `read_valid_o` is produced for a pending request.

## Structure
- Shared package `pca9685_pkg` holds:
  - address constants: MODE1 0x00, LED0_ON_L 0x06, LED15_OFF_H 0x45, ALL_LED_ON_L 0xFA, ALL_LED_OFF_H 0xFD, PRESCALE 0xFE;
  - `MODE1_AI_BIT` = 5;
  - the reader state enum;
  - a `reg_byte(blob, addr)` helper, shared with `register_data` and its bench.
- One sub-module, `led_snapshot`, holds the 4-byte capture register, `snap_base`, `snap_valid` and the hit compare.

## Test plan
- Single read: after reset, write 0x04 = 0xAA via `register_data`, set pointer 0x04, one `read_req_i` -> `read_data_o` = 0xAA at N+2 with a one-cycle `read_valid_o`.
- Auto-increment: MODE1 = 0x20, LED0 bytes 0x06..0x09 = DE 4D BE EF, pointer 0x06, four req/ack pairs -> DE, 4D, BE, EF; `pointer_o` = 0x0A.
- AI off: MODE1 = 0x00, pointer 0x06, three req/ack -> DE DE DE; `pointer_o` stays 0x06.
- Coherency: AI on, read 0x42 (ON_L = 0x11), then rewrite 0x43 = 0x99 in the blob, read next -> old 0x43 value. After `stop_i` and re-pointing to 0x43 -> 0x99.
- Reserved/ALL_LED/wrap: blob 0xFC = 0xBE, pointer 0xFC -> 0x00; pointer 0xFF with AI, ack -> `pointer_o` = 0x00; pointer 0x50 -> 0x00.
- Reset mid-burst: assert `rst_i` in FETCH -> no `read_valid_o`; `pointer_o` = 0x00, `busy_o` = 0 next cycle.
